lifo_memory_responder: RTL and testbench
========================================

Name: lifo_memory_responder

Overview:
- Storage array on the responder side of the stack/queue controller memory interface.
- Accepts the controller's write and read ports and holds DEPTH words of WIDTH bits.
- After reset, runs a clear sequence that writes INIT_VALUE to every entry, then signals ready.
- Supports combinational or registered read, and flags out-of-range accesses.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of entries; need not be a power of two.
- DEPTH_LOG2, CLOG2(DEPTH), address width.
- REGISTERED_READ, 0, 0 = combinational read (0-cycle latency); 1 = read data registered (1-cycle latency).
- INIT_VALUE, 0, WIDTH-bit value written to every entry by the clear sequence.

Ports:
- clock  input  1  memory clock; connected to the controller's memory_clock.
- resetn  input  1  asynchronous active-low reset.
- ready  output  1  high once the clear sequence completes.
- write_enable  input  1  write strobe.
- write_address  input  DEPTH_LOG2  write address.
- write_data  input  WIDTH  write data.
- read_enable  input  1  read strobe.
- read_address  input  DEPTH_LOG2  read address.
- read_data  output  WIDTH  read data.
- read_valid  output  1  read_data holds a valid read result.
- access_error  output  1  one-cycle pulse for an out-of-range or pre-ready access.

Behaviour:
- Reset: clock is `clock`; reset is `resetn`, asynchronous, active-low.
  - Reset values: ready=0, access_error=0, read_valid=0, read_data=0.
  - FSM enters CLEAR with clear counter=0. Array contents are not reset.
- FSM CLEAR:
  - Each cycle writes INIT_VALUE to entry[counter], then counter+1.
  - After the cycle with counter==DEPTH-1, moves to READY, so ready rises exactly DEPTH cycles after reset release.
- FSM READY: terminal state; only reset leaves it. Reset asserted mid-CLEAR restarts at counter 0.
- Accesses during CLEAR:
  - write_enable is ignored.
  - Reads return 0 with read_valid=0.
  - Any strobe pulses access_error on the next cycle.
- Write (READY): on the clock edge, entry[write_address] <= write_data when write_enable=1 and write_address<DEPTH.
- Read, REGISTERED_READ=0:
  - read_data = entry[read_address] combinationally while read_enable=1 and in range; otherwise 0.
  - read_valid = read_enable & ready & in-range, combinational.
- Read, REGISTERED_READ=1:
  - On the edge with read_enable=1, read_data <= entry[read_address] and read_valid <= 1.
  - With read_enable=0, read_valid <= 0 and read_data holds its last value.
- Out of range (address>=DEPTH, possible only when DEPTH is not a power of two):
  - The write is dropped; the read returns 0 with read_valid=0.
  - access_error is registered, high for exactly one cycle after the offending cycle. Write and read errors in the same cycle give a single pulse.
- Same-address read and write in one cycle, without forwarding: the read returns the pre-write contents in both read modes.
- Simultaneous read and write to different addresses are fully independent.

Optional Feature:
- Macro: LIFO_MEMORY_RESPONDER_WRITE_FORWARDING_EN.
- Defined: when write_enable=1, read_enable=1, read_address==write_address (in range, READY), read_data returns write_data.
  - Combinational in REGISTERED_READ=0 mode.
  - Registered on the edge in REGISTERED_READ=1 mode.
- Undefined: old-data semantics as above.

Decomposition:
- Shared package/header: FSM state encodings CLEAR=1'b0 and READY=1'b1; CLOG2 macro from clog2.vh.
- Sub-module memory_clear_sequencer: owns the FSM and counter; outputs clear_write_enable, clear_address and ready. Parent muxes clear vs user write port.

Test Plan:
- Reset release, WIDTH=8, DEPTH=4, INIT_VALUE=8'hA5 -> ready=0 for 4 cycles then 1; reads of addresses 0..3 return 8'hA5.
- Write 8'h3C to addr 2, then read addr 2 -> combinational mode: read_data=8'h3C in the same cycle as read_enable; registered mode: read_data=8'h3C, read_valid=1 one cycle later.
- Same cycle, write 8'h77 and read addr 1 (holding 8'h11) -> 8'h11 without the macro, 8'h77 with LIFO_MEMORY_RESPONDER_WRITE_FORWARDING_EN.
- DEPTH=5, write 8'hFF to addr 6 -> access_error high exactly one cycle; entries 0..4 unchanged; read addr 6 returns 0 with read_valid=0.
- Read strobe during CLEAR -> read_valid=0, access_error pulses; resetn low at counter=2 then released -> ready rises exactly 4 cycles (DEPTH=4) after release.
- Connect to the stack controller, push 1,2,3, pop+push 9, pop x2 -> pops return 9 then 2.

Source files
------------

// File: rtl/lifo_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// lifo_memory_responder_pkg
// Shared definitions for the LIFO memory responder slice:
//   - clear_state_e : clear-sequencer FSM encoding (CLEAR = 1'b0, READY = 1'b1)
//   - clog2_min1    : ceiling log2 used to size address/index fields. It never
//                     returns less than 1 so that a one-entry memory still gets
//                     a legal one-bit address.
// -----------------------------------------------------------------------------
package lifo_memory_responder_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_e;

  function automatic int clog2_min1(input int value);
    int width;
    width = 32'sd1;
    while ((32'sd1 <<< width) < value) begin
      width = width + 32'sd1;
    end
    return width;
  endfunction

endpackage

// File: rtl/lifo_memory_responder_if.sv
// -----------------------------------------------------------------------------
// lifo_memory_responder_if
// Memory bus between the stack/queue controller (master) and the storage
// responder (slave).
//   write_enable / write_address / write_data : write port (master -> slave)
//   read_enable  / read_address               : read request (master -> slave)
//   read_data / read_valid                    : read response (slave -> master)
//   access_error                              : one-cycle error pulse
//   ready                                     : clear sequence finished
// Parameters: WIDTH (data bits), ADDR_W (address bits).
// -----------------------------------------------------------------------------
interface lifo_memory_responder_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);

  logic              ready;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [WIDTH-1:0]  write_data;
  logic              read_enable;
  logic [ADDR_W-1:0] read_address;
  logic [WIDTH-1:0]  read_data;
  logic              read_valid;
  logic              access_error;

  modport master (
    output write_enable, write_address, write_data,
    output read_enable, read_address,
    input  ready, read_data, read_valid, access_error
  );

  modport slave (
    input  write_enable, write_address, write_data,
    input  read_enable, read_address,
    output ready, read_data, read_valid, access_error
  );

endinterface

// File: rtl/lifo_memory_responder_clear_sequencer.sv
// -----------------------------------------------------------------------------
// memory_clear_sequencer
// After reset release, walks every entry of the array once (one entry per
// clock) so the parent can write the initial value, then parks in READY until
// the next reset. An asynchronous reset at any point restarts from entry 0.
// Ports:
//   clock                : memory clock
//   resetn               : asynchronous active-low reset
//   clear_write_enable_o : high while the sequence owns the write port
//   clear_address_o      : entry being initialised this cycle
//   ready_o              : high once every entry has been written
// Parameters: DEPTH (entries), ADDR_W (index width).
// -----------------------------------------------------------------------------
module memory_clear_sequencer
  import lifo_memory_responder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              resetn,
  output logic              clear_write_enable_o,
  output logic [ADDR_W-1:0] clear_address_o,
  output logic              ready_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 32'sd1);

  clear_state_e      state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;

  // State and clear-counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: one entry per cycle, READY after the last entry
  always_comb begin
    state_d              = state_q;
    count_d              = count_q;
    clear_write_enable_o = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_write_enable_o = 1'b1;
        if (count_q == LAST_ADDR) begin
          state_d = READY;
          count_d = '0;
        end else begin
          count_d = count_q + ADDR_W'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
        count_d = '0;
      end
    endcase
  end

  assign clear_address_o = count_q;
  assign ready_o         = (state_q == READY);

endmodule

// File: rtl/lifo_memory_responder.sv
// -----------------------------------------------------------------------------
// lifo_memory_responder
// Storage array on the responder side of the stack/queue controller memory
// bus. Holds DEPTH words of WIDTH bits, initialises every entry to INIT_VALUE
// after reset, then serves one write and one read per cycle.
// Ports:
//   clock  : memory clock (controller's memory_clock)
//   resetn : asynchronous active-low reset
//   bus_if : slave side of lifo_memory_responder_if (write port, read port,
//            read_data/read_valid, access_error, ready)
// Parameters:
//   WIDTH, DEPTH (need not be a power of two), DEPTH_LOG2 (address width),
//   REGISTERED_READ (0 = combinational read, 1 = one-cycle registered read),
//   INIT_VALUE (word written to every entry by the clear sequence).
// Build option:
//   LIFO_MEMORY_RESPONDER_WRITE_FORWARDING_EN - when defined, a read that hits
//   the address being written in the same cycle returns the new write data
//   instead of the old contents.
// -----------------------------------------------------------------------------
module lifo_memory_responder
  import lifo_memory_responder_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEPTH           = 4,
  parameter int               DEPTH_LOG2      = clog2_min1(DEPTH),
  parameter int               REGISTERED_READ = 0,
  parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
  input logic                    clock,
  input logic                    resetn,
  lifo_memory_responder_if.slave bus_if
);

  // Index width actually needed for the array; the bus address may be wider.
  localparam int IDX_W = clog2_min1(DEPTH);
  // Depth widened by one bit so the range check works for power-of-two depths.
  localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef LIFO_MEMORY_RESPONDER_WRITE_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  ready_s;
  logic                  clear_we_s;
  logic [IDX_W-1:0]      clear_addr_s;

  logic [DEPTH_LOG2-1:0] wr_addr_s;
  logic [DEPTH_LOG2-1:0] rd_addr_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  fwd_hit_s;
  logic [WIDTH-1:0]      rd_word_s;
  logic                  error_d;
  logic                  error_q;

  memory_clear_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_clear_seq (
    .clock                (clock),
    .resetn               (resetn),
    .clear_write_enable_o (clear_we_s),
    .clear_address_o      (clear_addr_s),
    .ready_o              (ready_s)
  );

  assign wr_addr_s = bus_if.write_address;
  assign rd_addr_s = bus_if.read_address;
  // Truncation is lossless whenever the address is in range, which is the
  // only time the index is used.
  assign wr_idx_s  = IDX_W'(wr_addr_s);
  assign rd_idx_s  = IDX_W'(rd_addr_s);

  // Access decode: range check, readiness gating, forwarding and error cause
  always_comb begin
    wr_in_range_s = ({1'b0, wr_addr_s} < DEPTH_W);
    rd_in_range_s = ({1'b0, rd_addr_s} < DEPTH_W);
    wr_ok_s       = ready_s & bus_if.write_enable & wr_in_range_s;
    rd_ok_s       = ready_s & bus_if.read_enable & rd_in_range_s;
    fwd_hit_s     = FWD_EN & wr_ok_s & rd_ok_s & (rd_addr_s == wr_addr_s);
    if (fwd_hit_s) begin
      rd_word_s = bus_if.write_data;
    end else begin
      rd_word_s = mem_q[rd_idx_s];
    end
    // Write and read faults in one cycle collapse into a single pulse.
    error_d = (~ready_s & (bus_if.write_enable | bus_if.read_enable))
            | (bus_if.write_enable & ~wr_in_range_s)
            | (bus_if.read_enable & ~rd_in_range_s);
  end

  // Array write port: clear sequence owns it until ready, then user writes
  always_ff @(posedge clock) begin
    if (clear_we_s) begin
      mem_q[clear_addr_s] <= INIT_VALUE;
    end else if (wr_ok_s) begin
      mem_q[wr_idx_s] <= bus_if.write_data;
    end
  end

  // Access-error register: pulses the cycle after the offending access
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  generate
    if (REGISTERED_READ != 32'sd0) begin : g_reg_read
      logic [WIDTH-1:0] read_data_q;
      logic             read_valid_q;

      // Registered read: data captured on a read strobe, held otherwise
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          read_data_q  <= '0;
          read_valid_q <= 1'b0;
        end else if (bus_if.read_enable) begin
          read_valid_q <= rd_ok_s;
          read_data_q  <= rd_ok_s ? rd_word_s : '0;
        end else begin
          read_valid_q <= 1'b0;
        end
      end

      assign bus_if.read_data  = read_data_q;
      assign bus_if.read_valid = read_valid_q;
    end else begin : g_comb_read
      assign bus_if.read_data  = rd_ok_s ? rd_word_s : '0;
      assign bus_if.read_valid = rd_ok_s;
    end
  endgenerate

  assign bus_if.ready        = ready_s;
  assign bus_if.access_error = error_q;

endmodule

// File: tb/tb_lifo_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_lifo_memory_responder
// Two responders share one stimulus stream:
//   dut_a : DEPTH=5, combinational read
//   dut_b : DEPTH=4 with a 3-bit address bus, registered read
// Inputs change 1 time unit after each rising edge; a monitor samples every
// falling edge and pops one expected record per cycle from a scoreboard
// queue filled by a reference model of the memory (arrays + cycle count).
// -----------------------------------------------------------------------------
module tb_lifo_memory_responder;

  localparam int         W       = 8;
  localparam int         AW      = 3;
  localparam int         DEPTH_A = 5;
  localparam int         DEPTH_B = 4;
  localparam logic [7:0] INIT    = 8'hA5;

`ifdef LIFO_MEMORY_RESPONDER_WRITE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic          we, re;
  logic [AW-1:0] wa, ra;
  logic [W-1:0]  wd;

  lifo_memory_responder_if #(.WIDTH(W), .ADDR_W(AW)) bus_a ();
  lifo_memory_responder_if #(.WIDTH(W), .ADDR_W(AW)) bus_b ();

  assign bus_a.write_enable  = we;
  assign bus_a.write_address = wa;
  assign bus_a.write_data    = wd;
  assign bus_a.read_enable   = re;
  assign bus_a.read_address  = ra;
  assign bus_b.write_enable  = we;
  assign bus_b.write_address = wa;
  assign bus_b.write_data    = wd;
  assign bus_b.read_enable   = re;
  assign bus_b.read_address  = ra;

  lifo_memory_responder #(
    .WIDTH(W), .DEPTH(DEPTH_A), .DEPTH_LOG2(AW), .REGISTERED_READ(0), .INIT_VALUE(INIT)
  ) dut_a (
    .clock(clock), .resetn(resetn), .bus_if(bus_a)
  );

  lifo_memory_responder #(
    .WIDTH(W), .DEPTH(DEPTH_B), .DEPTH_LOG2(AW), .REGISTERED_READ(1), .INIT_VALUE(INIT)
  ) dut_b (
    .clock(clock), .resetn(resetn), .bus_if(bus_b)
  );

  typedef struct {
    bit         rdy_a, rdy_b;
    bit         val_a, val_b;
    logic [7:0] dat_a, dat_b;
    bit         err_a, err_b;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model state
  logic [7:0] ref_mem [2][8];
  int         slot;          // cycles since reset release
  bit         pend_val_b;    // dut_b read_valid after the coming edge
  logic [7:0] pend_dat_b;    // dut_b read_data after the coming edge
  bit         pend_err [2];  // access_error after the coming edge

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what both memories must show.
  task automatic apply(input bit we_i, input int wa_i, input logic [7:0] wd_i,
                       input bit re_i, input int ra_i);
    exp_t       e;
    int         depth;
    bit         rdy, rd_ok, wr_ok;
    logic [7:0] word;
    we = we_i; wa = AW'(wa_i); wd = wd_i; re = re_i; ra = AW'(ra_i);
    e.val_b = pend_val_b;
    e.dat_b = pend_dat_b;
    e.err_a = pend_err[0];
    e.err_b = pend_err[1];
    for (int d = 0; d < 2; d++) begin
      depth = (d == 0) ? DEPTH_A : DEPTH_B;
      rdy   = (slot >= depth);
      rd_ok = rdy && re_i && (ra_i < depth);
      wr_ok = rdy && we_i && (wa_i < depth);
      word  = (FWD && rd_ok && wr_ok && ra_i == wa_i) ? wd_i : ref_mem[d][ra_i];
      pend_err[d] = (!rdy && (we_i || re_i)) || (we_i && wa_i >= depth) || (re_i && ra_i >= depth);
      if (d == 0) begin
        e.rdy_a = rdy;
        e.val_a = rd_ok;
        e.dat_a = rd_ok ? word : 8'h00;
      end else begin
        e.rdy_b = rdy;
        if (re_i) begin
          pend_val_b = rd_ok;
          pend_dat_b = rd_ok ? word : 8'h00;
        end else begin
          pend_val_b = 1'b0;
        end
      end
      if (wr_ok) ref_mem[d][wa_i] = wd_i;
    end
    slot++;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit we_i, input int wa_i, input logic [7:0] wd_i,
                       input bit re_i, input int ra_i);
    @(posedge clock);
    #1;
    apply(we_i, wa_i, wd_i, re_i, ra_i);
  endtask

  // Assert reset for 'hold' cycles checking reset values, then release it.
  // The caller drives cycle 0 with apply() right after this returns.
  task automatic do_reset(input int hold);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;
    exp_q.delete();
    repeat (hold) begin
      @(negedge clock);
      chk("rst_ready_a", bus_a.ready, 8'h00);
      chk("rst_ready_b", bus_b.ready, 8'h00);
      chk("rst_err_a", bus_a.access_error, 8'h00);
      chk("rst_err_b", bus_b.access_error, 8'h00);
      chk("rst_valid_a", bus_a.read_valid, 8'h00);
      chk("rst_valid_b", bus_b.read_valid, 8'h00);
      chk("rst_data_a", bus_a.read_data, 8'h00);
      chk("rst_data_b", bus_b.read_data, 8'h00);
    end
    @(posedge clock);
    #1;
    resetn     = 1'b1;
    slot       = 0;
    pend_val_b = 1'b0;
    pend_dat_b = 8'h00;
    pend_err   = '{1'b0, 1'b0};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        ref_mem[d][i] = INIT;
  endtask

  // Monitor: one expected record per cycle, compared on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("ready_a", bus_a.ready, mon_e.rdy_a);
        chk("ready_b", bus_b.ready, mon_e.rdy_b);
        chk("valid_a", bus_a.read_valid, mon_e.val_a);
        chk("valid_b", bus_b.read_valid, mon_e.val_b);
        chk("data_a", bus_a.read_data, mon_e.dat_a);
        chk("data_b", bus_b.read_data, mon_e.dat_b);
        chk("err_a", bus_a.access_error, mon_e.err_a);
        chk("err_b", bus_b.access_error, mon_e.err_b);
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0t expected < 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0;

    // Strobes during CLEAR, then reset again with the clear counter at 2
    do_reset(3);
    apply(1'b0, 0, 8'h00, 1'b1, 0);
    cycle(1'b1, 1, 8'h55, 1'b0, 0);
    do_reset(2);
    apply(1'b0, 0, 8'h00, 1'b0, 0);
    repeat (6) cycle(1'b0, 0, 8'h00, 1'b0, 0);

    // Initial contents (address 4 is out of range only for dut_b)
    for (int a = 0; a < 5; a++) cycle(1'b0, 0, 8'h00, 1'b1, a);

    // Write then read back
    cycle(1'b1, 2, 8'h3C, 1'b0, 0);
    cycle(1'b0, 0, 8'h00, 1'b1, 2);

    // Same-address read and write in one cycle
    cycle(1'b1, 1, 8'h11, 1'b0, 0);
    cycle(1'b1, 1, 8'h77, 1'b1, 1);
    cycle(1'b0, 0, 8'h00, 1'b1, 1);

    // Out-of-range write, contents check, out-of-range read
    cycle(1'b1, 6, 8'hFF, 1'b0, 0);
    cycle(1'b0, 0, 8'h00, 1'b0, 0);
    for (int a = 0; a < 5; a++) cycle(1'b0, 0, 8'h00, 1'b1, a);
    cycle(1'b0, 0, 8'h00, 1'b1, 6);
    cycle(1'b1, 6, 8'h01, 1'b1, 7);
    cycle(1'b0, 0, 8'h00, 1'b0, 0);

    // Stack usage: push 1,2,3; pop+push 9; pop; pop
    cycle(1'b1, 0, 8'h01, 1'b0, 0);
    cycle(1'b1, 1, 8'h02, 1'b0, 0);
    cycle(1'b1, 2, 8'h03, 1'b0, 0);
    cycle(1'b1, 2, 8'h09, 1'b1, 2);
    cycle(1'b0, 0, 8'h00, 1'b1, 2);
    cycle(1'b0, 0, 8'h00, 1'b1, 1);

    // Random traffic
    repeat (400) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    cycle(1'b0, 0, 8'h00, 1'b0, 0);
    cycle(1'b0, 0, 8'h00, 1'b0, 0);
    @(posedge clock);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
